// File: rtl/loader_pkg.sv
// Shared FSM encoding and block-count helper for the block image loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        FINISH
    } state_t;

    function automatic logic [31:0] ceil_div(
        input logic [31:0] num,
        input logic [31:0] den
    );
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/loader_buffer.sv
// Word buffer: one synchronous write port, registered read port.
// A same-address read/write returns the previously stored word.
module loader_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/image_block_loader.sv
// Fetches an N*N*C image through the DMA in fixed blocks into a word buffer.
// Optional LOADER_ZERO_PAD_EN: last block always drains a full block, tail zeroed.
module image_block_loader
    import loader_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int BLOCK_SIZE = 25,
    parameter int SIZE_W     = 6,
    parameter int CH_W       = 2,
    parameter int DEPTH      = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [SIZE_W-1:0]            img_size,
    input  logic [CH_W-1:0]              num_ch,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         dma_req,
    output logic [ADDR_W-1:0]            dma_addr,
    output logic                         dma_rw,
    input  logic                         dma_valid,
    input  logic [BLOCK_SIZE*DATA_W-1:0] dma_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [DATA_W-1:0]            rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = 2 * SIZE_W + CH_W;
    localparam int IW = $clog2(BLOCK_SIZE + 1);
    localparam int PW = $clog2(DEPTH + BLOCK_SIZE) + 1;

    state_t                      r_state;
    logic [TW-1:0]               r_total;
    logic [TW-1:0]               r_nblk;
    logic [TW-1:0]               r_blk;
    logic [PW-1:0]               r_wptr;
    logic [IW-1:0]               r_idx;
    logic [BLOCK_SIZE*DATA_W-1:0] r_block;
    logic [ADDR_W-1:0]           r_dma_addr;
    logic                        r_dma_req;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;

    logic [TW-1:0]     w_total;
    logic [TW-1:0]     w_nblk;
    logic              w_oversize;
    logic              w_idx_end;
    logic              w_blk_end;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;

    assign w_total    = TW'(img_size) * TW'(img_size) * TW'(num_ch);
    assign w_nblk     = TW'(ceil_div(32'(w_total), 32'(BLOCK_SIZE)));
    assign w_oversize = 32'(w_total) > DEPTH;
    assign w_idx_end  = r_idx == IW'(BLOCK_SIZE - 1);

`ifdef LOADER_ZERO_PAD_EN
    assign w_blk_end = w_idx_end;
    assign w_we      = (r_state == DRAIN) && (32'(r_wptr) < DEPTH);
    assign w_wdata   = (32'(r_wptr) < 32'(r_total)) ? r_block[DATA_W-1:0] : '0;
`else
    logic w_last_word;
    assign w_last_word = (32'(r_wptr) + 32'd1) >= 32'(r_total);
    assign w_blk_end   = w_idx_end || w_last_word;
    assign w_we        = (r_state == DRAIN);
    assign w_wdata     = r_block[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_total    <= '0;
            r_nblk     <= '0;
            r_blk      <= '0;
            r_wptr     <= '0;
            r_idx      <= '0;
            r_block    <= '0;
            r_dma_addr <= '0;
            r_dma_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_total    <= w_total;
                        r_nblk     <= w_nblk;
                        r_blk      <= '0;
                        r_wptr     <= '0;
                        r_idx      <= '0;
                        r_dma_addr <= base_addr;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_total == '0) begin
                            r_state <= FINISH;
                        end else if (w_oversize) begin
                            r_err   <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_dma_req <= 1'b1;
                            r_state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dma_valid) begin
                        r_block   <= dma_data;
                        r_dma_req <= 1'b0;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Shift so the next word to write is always in the low slot
                    r_block <= r_block >> DATA_W;
                    r_wptr  <= r_wptr + PW'(1);
                    r_idx   <= r_idx + IW'(1);
                    if (w_blk_end) begin
                        r_idx <= '0;
                        r_blk <= r_blk + TW'(1);
                        if ((r_blk + TW'(1)) < r_nblk) begin
                            r_dma_addr <= r_dma_addr + ADDR_W'(BLOCK_SIZE);
                            r_dma_req  <= 1'b1;
                            r_state    <= REQ;
                        end else begin
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    loader_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign dma_req  = r_dma_req;
    assign dma_addr = r_dma_addr;
    assign dma_rw   = r_dma_req;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_image_block_loader.sv
// Scoreboard bench for image_block_loader: random DMA responder, buffer model.
`timescale 1ns/1ps
module tb_image_block_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 20;
    localparam int BS     = 25;
    localparam int SIZE_W = 6;
    localparam int CH_W   = 2;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [SIZE_W-1:0]      img_size = '0;
    logic [CH_W-1:0]        num_ch = '0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic                   dma_req;
    logic [ADDR_W-1:0]      dma_addr;
    logic                   dma_rw;
    logic                   dma_valid = 1'b0;
    logic [BS*DATA_W-1:0]   dma_data = '0;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [AW-1:0]          rd_addr = '0;
    logic [DATA_W-1:0]      rd_data;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_req_q[$];
    logic              exp_done_q[$];
    logic [DATA_W-1:0] rd_exp_q[$];
    logic [AW-1:0]     rd_a_q[$];
    logic [DATA_W-1:0] sent_words[$];
    logic [DATA_W-1:0] model_mem[DEPTH];
    bit                known[DEPTH];

    int   lat_acc = 0;
    int   done_cnt = 0;
    logic rd_en_tb = 1'b0;
    logic rd_v_d = 1'b0;
    logic req_prev = 1'b0;

    int   cur_T, cur_B, cur_d0;
    bit   cur_over;

    always #5 clk = ~clk;

    image_block_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_size  (img_size),
        .num_ch    (num_ch),
        .base_addr (base_addr),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_rw    (dma_rw),
        .dma_valid (dma_valid),
        .dma_data  (dma_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_v_d <= rd_en_tb;

    // Monitor: pops expectations whenever the DUT presents an output
    initial begin
        forever begin
            @(negedge clk);
            if (dma_req && !req_prev) begin
                check("dma_rw", dma_rw, 1);
                if (exp_req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req: got addr %0h expected none", dma_addr);
                end else begin
                    check("dma_addr", dma_addr, exp_req_q.pop_front());
                end
            end
            req_prev = dma_req;
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    check("done_err", err, exp_done_q.pop_front());
                end
            end
            if (rd_v_d) begin
                if (rd_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_queue: got read with empty queue expected entry");
                end else begin
                    logic [AW-1:0] a;
                    a = rd_a_q.pop_front();
                    check($sformatf("rd_data[%0d]", a), rd_data, rd_exp_q.pop_front());
                end
            end
        end
    end

    // DMA responder: random latency, random block data, spurious valids when idle
    initial begin
        int d;
        logic [DATA_W-1:0] w;
        forever begin
            @(negedge clk);
            if (dma_req) begin
                dma_valid = 1'b0;
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                if (dma_req) begin
                    lat_acc += d + 1;
                    for (int i = 0; i < BS; i++) begin
                        w = DATA_W'($urandom);
                        dma_data[i*DATA_W +: DATA_W] = w;
                        sent_words.push_back(w);
                    end
                    dma_valid = 1'b1;
                    @(negedge clk);
                    dma_valid = 1'b0;
                end
            end else begin
                for (int i = 0; i < BS; i++)
                    dma_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                dma_valid = ($urandom_range(0, 7) == 0);
            end
        end
    end

    task automatic issue_load(input int n, input int c, input logic [ADDR_W-1:0] base);
        cur_T    = n * n * c;
        cur_B    = (cur_T + BS - 1) / BS;
        cur_over = cur_T > DEPTH;
        cur_d0   = done_cnt;
        sent_words.delete();
        lat_acc = 0;
        if (!cur_over)
            for (int k = 0; k < cur_B; k++)
                exp_req_q.push_back(base + ADDR_W'(k * BS));
        exp_done_q.push_back(cur_over);
        @(negedge clk);
        img_size  = SIZE_W'(n);
        num_ch    = CH_W'(c);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_after_start", err, cur_over);
    endtask

    task automatic readback();
        for (int a = 0; a < DEPTH; a++) begin
            if (known[a]) begin
                @(negedge clk);
                rd_addr  = AW'(a);
                rd_en_tb = 1'b1;
                rd_exp_q.push_back(model_mem[a]);
                rd_a_q.push_back(AW'(a));
            end
        end
        @(negedge clk);
        rd_en_tb = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_load();
        int cyc;
        int exp_lat;
        int fill;
        cyc = 1;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", cyc);
        end else begin
            check("busy_at_done", busy, 0);
`ifdef LOADER_ZERO_PAD_EN
            fill = cur_B * BS;
`else
            fill = cur_T;
`endif
            exp_lat = (cur_T == 0 || cur_over) ? 2 : 2 + lat_acc + fill;
            check("latency", cyc, exp_lat);
        end
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, cur_d0 + 1);
        check("reqs_left", exp_req_q.size(), 0);
        check("words_sent", sent_words.size(),
              (cur_over || cur_T == 0) ? 0 : cur_B * BS);
        exp_req_q.delete();
        if (!cur_over && sent_words.size() >= cur_T) begin
            for (int w = 0; w < cur_T; w++) begin
                model_mem[w] = sent_words[w];
                known[w] = 1'b1;
            end
`ifdef LOADER_ZERO_PAD_EN
            for (int w = cur_T; w < cur_B * BS && w < DEPTH; w++) begin
                model_mem[w] = '0;
                known[w] = 1'b1;
            end
`endif
        end
        readback();
    endtask

    task automatic do_load(input int n, input int c, input logic [ADDR_W-1:0] base);
        issue_load(n, c, base);
        finish_load();
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_dma_req", dma_req, 0);
        check("rst_dma_rw", dma_rw, 0);
        check("rst_dma_addr", dma_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(5, 1, 20'h00100);
        do_load(5, 3, 20'h00200);
        do_load(7, 1, 20'h00000);
        do_load(0, 2, 20'h00400);
        do_load(20, 3, 20'h00500);
        do_load(4, 2, 20'hFFFF0);

        // Reset during the drain of the second block of an N=7 load
        issue_load(7, 1, 20'h03000);
        cyc = 0;
        while (sent_words.size() < 2 * BS && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_second_blk", sent_words.size(), 2 * BS);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dma_req", dma_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_req_q.delete();
        exp_done_q.delete();
        for (int a = 0; a < 49; a++) known[a] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(7, 1, 20'h03000);

        for (int r = 0; r < 6; r++)
            do_load($urandom_range(0, 20), $urandom_range(0, 3), ADDR_W'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
